// File: rtl/sysid_regbank.sv
// System ID register bank: ID, build timestamp, capabilities, coherent 64-bit
// uptime counter, scratch and control, behind a pipelined Avalon-MM read port.
module sysid_regbank #(
  parameter logic [31:0] ID_VALUE     = 32'h583483B9,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          ADDR_WIDTH   = 3,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  generate
    if (ADDR_WIDTH < 3 || ADDR_WIDTH > 8 || READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_param
      $error("sysid_regbank: ADDR_WIDTH must be 3..8 and READ_LATENCY 1..3");
    end
  endgenerate

  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_TS      = 3'd1;
  localparam logic [2:0] A_CAPS    = 3'd2;
  localparam logic [2:0] A_UP_LO   = 3'd3;
  localparam logic [2:0] A_UP_HI   = 3'd4;
  localparam logic [2:0] A_SCRATCH = 3'd5;
  localparam logic [2:0] A_CONTROL = 3'd6;

  localparam logic [31:0] CAPS_WORD = {16'h0002, 8'd8, 8'(READ_LATENCY)};

  logic [63:0] r_counter;
  logic [31:0] r_hi_shadow;
  logic        r_freeze;

  logic [8:0]  w_addr_ext;
  logic        w_addr_in_map;
  logic [2:0]  w_idx;
  logic        w_rd_accept;
  logic        w_wr_scratch;
  logic        w_wr_ctrl;
  logic        w_clear;
  logic [31:0] w_scratch;
  logic [31:0] w_rd_mux;

  assign w_addr_ext    = 9'(address);
  assign w_addr_in_map = (w_addr_ext < 9'd8);
  assign w_idx         = w_addr_ext[2:0];
  assign w_rd_accept   = read && !write;
  assign w_wr_scratch  = write && w_addr_in_map && (w_idx == A_SCRATCH);
  assign w_wr_ctrl     = write && w_addr_in_map && (w_idx == A_CONTROL) && byteenable[0];
  assign w_clear       = w_wr_ctrl && writedata[0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scratch_byte
      logic [7:0] r_byte;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_byte <= 8'h00;
        end else if (w_wr_scratch && byteenable[gi]) begin
          r_byte <= writedata[8*gi +: 8];
        end
      end
      assign w_scratch[8*gi +: 8] = r_byte;
    end
  endgenerate

  // Clear beats increment and leaves freeze untouched; freeze is only undone by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_counter   <= 64'd0;
      r_hi_shadow <= 32'd0;
      r_freeze    <= 1'b0;
    end else begin
      if (w_clear) begin
        r_counter <= 64'd0;
      end else if (!r_freeze) begin
        r_counter <= r_counter + 64'd1;
      end
      if (w_clear) begin
        r_hi_shadow <= 32'd0;
      end else if (w_rd_accept && w_addr_in_map && (w_idx == A_UP_LO)) begin
        r_hi_shadow <= r_counter[63:32];
      end
      if (w_wr_ctrl && writedata[1]) begin
        r_freeze <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    if (w_addr_in_map) begin
      case (w_idx)
        A_ID:      w_rd_mux = ID_VALUE;
        A_TS:      w_rd_mux = TIMESTAMP;
        A_CAPS:    w_rd_mux = CAPS_WORD;
        A_UP_LO:   w_rd_mux = r_counter[31:0];
        A_UP_HI:   w_rd_mux = r_hi_shadow;
        A_SCRATCH: w_rd_mux = w_scratch;
        A_CONTROL: w_rd_mux = {30'd0, r_freeze, 1'b0};
        default:   w_rd_mux = 32'd0;
      endcase
    end
  end

  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [31:0]             r_pipe_dat [READ_LATENCY];

  // Data is captured at accept time so the returned word reflects the accept cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_dat[i] <= 32'd0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_accept;
      r_pipe_dat[0] <= w_rd_accept ? w_rd_mux : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end
    end
  end

  // Gating with reset suppresses the strobe of a read caught in flight by reset.
  assign readdatavalid = r_pipe_vld[READ_LATENCY-1] && !reset;
  assign readdata      = reset ? 32'd0 : r_pipe_dat[READ_LATENCY-1];

endmodule

// File: doc/sysid_regbank.md
Name: sysid_regbank

Overview:
- Parametrised successor to the single-word system ID slave.
- Avalon-MM slave on the Nios II data master that exposes a small register bank:
  - system ID and build timestamp;
  - capability word;
  - atomically readable 64-bit uptime counter;
  - writable scratch register;
  - control register.
- Software uses it to confirm the hardware/software image match, measure elapsed cycles, and check bus access.
- Reads are pipelined with fixed, parameterised latency and a readdatavalid strobe.

Parameters:
- ID_VALUE, 32'h583483B9, value returned at word 0.
- TIMESTAMP, 32'h00000000, build timestamp returned at word 1.
- ADDR_WIDTH, 3, word-address width; must be 3..8.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal range 1..3.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request, accepted in the same cycle (no waitrequest).
- write  in  1  write request, accepted in the same cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  read data; valid only while readdatavalid=1.
- readdatavalid  out  1  one-cycle strobe per accepted read.

Interface decision: one clock; reset is synchronous and active-high. Clock port is named clock, reset port is named reset.

Behaviour:
- Reset (sampled on clock rising edge with reset=1) sets:
  - readdata=0, readdatavalid=0;
  - read pipeline flushed;
  - uptime counter=0, HI shadow=0, scratch=0, freeze=0.
- Reset asserted mid-read: no readdatavalid is produced for in-flight reads. readdatavalid=0 from the first cycle after reset is sampled.
- Register map (word addresses):
  - 0 ID (RO) = ID_VALUE.
  - 1 TIMESTAMP (RO) = TIMESTAMP.
  - 2 CAPS (RO) = {16'h0002 version, 8'd8 register count, 8'(READ_LATENCY)}.
  - 3 UPTIME_LO (RO): returns counter[31:0]. The same accept cycle loads counter[63:32] into the HI shadow.
  - 4 UPTIME_HI (RO): returns the HI shadow, not the live counter.
  - 5 SCRATCH (RW): byte-lane writes per byteenable.
  - 6 CONTROL:
    - write, with byteenable[0]=1: bit0=1 clears the counter and shadow (self-clearing, reads 0); bit1 sets freeze.
    - read returns {30'b0, freeze, 1'b0}.
  - 7 and any address >= 8: read 0, writes ignored.
- Read pipeline:
  - A read is accepted on any cycle with read=1 and write=0.
  - Data is sampled from register state as it stands at the accept cycle, before that cycle's writes take effect.
  - Data is presented with readdatavalid=1 exactly READ_LATENCY cycles later.
  - Back-to-back reads on consecutive cycles produce consecutive readdatavalid strobes in order, with no bubbles.
  - readdata returns to 0 on cycles where readdatavalid=0.
- Simultaneous read=1 and write=1: the write is performed; the read is ignored and no readdatavalid is generated.
- Uptime counter:
  - 64-bit; increments by 1 every cycle while freeze=0.
  - Wraps from 2^64-1 to 0 with no flag.
  - Clear and increment in the same cycle: clear wins, counter=0 on the next cycle.
  - Clear while freeze=1: counter=0 and stays frozen.
- Reading UPTIME_LO and then UPTIME_HI yields a coherent 64-bit value, even across a carry out of bit 31.
- Writes to read-only addresses have no effect on any state.
- Read latency in the counter domain: a read of UPTIME_LO accepted at cycle t, where counter=N at t, returns N regardless of READ_LATENCY.

Test Plan:
- Reset, then read words 0, 1, 2 back-to-back with READ_LATENCY=2:
  - readdatavalid high on cycles 2, 3, 4 after the first accept;
  - data 0x583483B9, 0x00000000, 0x00020802 in order.
- Write 0xDEADBEEF to SCRATCH with byteenable=4'b1111, then write 0x00000011 with byteenable=4'b0001. Read SCRATCH -> 0xDEADBE11.
- Force counter to 0x00000000_FFFFFFFE via CONTROL clear plus a cycle count. Read UPTIME_LO on the cycle the counter equals 0xFFFFFFFF, then UPTIME_HI several cycles later -> LO=0xFFFFFFFF, HI=0x00000000 (shadow, not the live value 1).
- Write CONTROL=0x2 (freeze), wait 100 cycles, read LO twice -> identical values. Write CONTROL=0x1 -> LO reads 0 and CONTROL reads 0x2.
- Assert read=1 and write=1 to SCRATCH with data 0x5 in the same cycle -> no readdatavalid; a subsequent read of SCRATCH returns 0x5.
- Issue a read, then assert reset on the next cycle -> no readdatavalid; after reset, SCRATCH=0 and LO is small (< 10).
